// File: rtl/rk_tape_pkg.sv
// rk_tape_pkg: shared types and defaults for the RK cassette player.
// Holds the player state enum, byte-count width and parameter defaults.
package rk_tape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PILOT,
        ST_SYNC,
        ST_DATA,
        ST_TRAIL
    } tape_state_t;

    localparam int          LEN_W         = 25;
    localparam int unsigned HALF_DIV_DEF  = 1536;
    localparam int unsigned PILOT_LEN_DEF = 256;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hE6;

endpackage

// File: rtl/rk_bit_serializer.sv
// rk_bit_serializer: Manchester byte shifter, MSB first, ~bit then bit.
// Ports: clk, reset, load/data (take byte when ready), clear (force level 0
// and go idle), ready (idle or on last clk of the byte), lsb_start (last clk
// before bit 0 begins), level (registered tape level).
module rk_bit_serializer #(
    parameter int unsigned HALF_DIV = 1536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       clear,
    output logic       ready,
    output logic       lsb_start,
    output logic       level
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [7:0]    sh;
    logic [2:0]    bit_left;
    logic          second;
    logic          run;
    logic          cell_end;

    assign cell_end  = run && (cnt == '0);
    assign ready     = !run || (cell_end && second && (bit_left == 3'd0));
    assign lsb_start = cell_end && second && (bit_left == 3'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            sh       <= 8'h00;
            bit_left <= 3'd0;
            second   <= 1'b0;
            run      <= 1'b0;
            level    <= 1'b0;
        end else if (clear) begin
            cnt      <= '0;
            second   <= 1'b0;
            bit_left <= 3'd0;
            run      <= 1'b0;
            level    <= 1'b0;
        end else if (load && ready) begin
            sh       <= data;
            bit_left <= 3'd7;
            second   <= 1'b0;
            level    <= ~data[7];
            cnt      <= CW'(HALF_DIV - 1);
            run      <= 1'b1;
        end else if (ready) begin
            // byte finished with nothing to send: hold level, freeze
            run <= 1'b0;
        end else if (run) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (!second) begin
                second <= 1'b1;
                level  <= sh[7];
                cnt    <= CW'(HALF_DIV - 1);
            end else begin
                second   <= 1'b0;
                bit_left <= bit_left - 3'd1;
                sh       <= {sh[6:0], 1'b0};
                level    <= ~sh[6];
                cnt      <= CW'(HALF_DIV - 1);
            end
        end
    end

endmodule

// File: rtl/rk_tape_player.sv
// rk_tape_player: plays a memory image as an RK cassette waveform:
// pilot zeros, sync byte, image bytes, then a low trailer.
// Ports: clk, reset, start/stop pulses, length (bytes), mem_rd/mem_addr
// fetch request, mem_valid/mem_data reply, tape_out level, busy, done,
// underrun (sticky, cleared on start).
module rk_tape_player
    import rk_tape_pkg::*;
#(
    parameter int unsigned HALF_DIV  = HALF_DIV_DEF,
    parameter int unsigned PILOT_LEN = PILOT_LEN_DEF,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] length,
    output logic             mem_rd,
    output logic [LEN_W-1:0] mem_addr,
    input  logic             mem_valid,
    input  logic [7:0]       mem_data,
    output logic             tape_out,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int TW = $clog2(2 * HALF_DIV);

    tape_state_t      state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] byte_cnt;
    logic [LEN_W-1:0] fetch_idx;
    logic [TW-1:0]    trail_cnt;
    logic [7:0]       hold;
    logic             hold_full;
    logic             pending;
    logic             avail;
    logic [7:0]       next_byte;
    logic             consume;
    logic             fetch;
    logic             stall;
    logic             trail_go;
    logic             ser_load;
    logic [7:0]       ser_byte;
    logic             ser_clear;
    logic             ser_ready;
    logic             ser_lsb;

    // a reply arriving on the boundary clk goes straight to the shifter
    assign avail     = hold_full || (pending && mem_valid);
    assign next_byte = hold_full ? hold : mem_data;
    assign consume   = ser_load &&
                       ((state == ST_SYNC) || (state == ST_DATA));
    assign fetch     = ser_lsb && !pending && !hold_full &&
                       ((state == ST_SYNC) || (state == ST_DATA)) &&
                       (fetch_idx < len_q);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        ser_load  = 1'b0;
        ser_byte  = 8'h00;
        ser_clear = 1'b0;
        stall     = 1'b0;
        trail_go  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_PILOT;
            end
            ST_PILOT: begin
                if (ser_ready) begin
                    ser_load = 1'b1;
                    if (byte_cnt == LEN_W'(PILOT_LEN)) begin
                        ser_byte  = SYNC_BYTE;
                        state_nxt = ST_SYNC;
                    end
                end
            end
            ST_SYNC, ST_DATA: begin
                if (ser_ready) begin
                    if (byte_cnt == len_q) begin
                        ser_clear = 1'b1;
                        trail_go  = 1'b1;
                        state_nxt = ST_TRAIL;
                    end else if (avail) begin
                        ser_load  = 1'b1;
                        ser_byte  = next_byte;
                        state_nxt = ST_DATA;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            ST_TRAIL: begin
                if (trail_cnt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (stop && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
            ser_load  = 1'b0;
            ser_clear = 1'b1;
            stall     = 1'b0;
            trail_go  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            byte_cnt   <= '0;
            fetch_idx  <= '0;
            trail_cnt  <= '0;
            hold       <= 8'h00;
            hold_full  <= 1'b0;
            pending    <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state  <= state_nxt;
            mem_rd <= 1'b0;
            done   <= (state == ST_TRAIL) && (state_nxt == ST_IDLE) && !stop;
            if (state == ST_IDLE) begin
                pending   <= 1'b0;
                hold_full <= 1'b0;
                if (start) begin
                    len_q     <= length;
                    byte_cnt  <= '0;
                    fetch_idx <= '0;
                    mem_addr  <= '0;
                    underrun  <= 1'b0;
                end
            end else if (state_nxt == ST_IDLE) begin
                pending   <= 1'b0;
                hold_full <= 1'b0;
            end else begin
                // byte_cnt counts pilot bytes, then restarts for data bytes
                if (ser_load) begin
                    byte_cnt <= (state_nxt == ST_SYNC) ? '0
                                                       : byte_cnt + 1'b1;
                end
                if (stall) underrun <= 1'b1;
                if (consume && hold_full) hold_full <= 1'b0;
                if (pending && mem_valid) begin
                    pending <= 1'b0;
                    if (!(consume && !hold_full)) begin
                        hold      <= mem_data;
                        hold_full <= 1'b1;
                    end
                end
                if (fetch) begin
                    mem_rd    <= 1'b1;
                    mem_addr  <= fetch_idx;
                    fetch_idx <= fetch_idx + 1'b1;
                    pending   <= 1'b1;
                end
                if (trail_go) begin
                    trail_cnt <= TW'(2 * HALF_DIV - 1);
                end else if ((state == ST_TRAIL) && (trail_cnt != '0)) begin
                    trail_cnt <= trail_cnt - 1'b1;
                end
            end
        end
    end

    rk_bit_serializer #(
        .HALF_DIV (HALF_DIV)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .data      (ser_byte),
        .clear     (ser_clear),
        .ready     (ser_ready),
        .lsb_start (ser_lsb),
        .level     (tape_out)
    );

endmodule

// File: tb/tb_rk_tape_player.sv
// tb_rk_tape_player: directed bench for rk_tape_player (HALF_DIV=4,
// PILOT_LEN=2) with a latency-programmable memory responder.
module tb_rk_tape_player;

    localparam int H  = 4;
    localparam int PL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [24:0] length;
    logic        mem_rd;
    logic [24:0] mem_addr;
    logic        mem_valid;
    logic [7:0]  mem_data;
    logic        tape_out;
    logic        busy;
    logic        done;
    logic        underrun;

    always #5 clk = ~clk;

    rk_tape_player #(
        .HALF_DIV  (H),
        .PILOT_LEN (PL),
        .SYNC_BYTE (8'hE6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .length    (length),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .tape_out  (tape_out),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  img [0:3] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
    int          lat = 3;
    int          pend_cnt = 0;
    logic [24:0] pend_addr = '0;
    int          rd_count = 0;
    logic [24:0] rd_addrs[$];

    // memory: answers each request lat clk later with a one-clk strobe
    initial begin
        mem_valid = 1'b0;
        mem_data  = 8'h00;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = img[pend_addr[1:0]];
                end
            end
            if (mem_rd) begin
                pend_addr = mem_addr;
                pend_cnt  = lat;
                rd_count++;
                rd_addrs.push_back(mem_addr);
            end
        end
    end

    logic cap_on = 1'b0;
    logic capturing = 1'b0;
    logic samples[$];
    int   done_cnt = 0;

    // waveform capture from the first high level until busy drops
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (cap_on) begin
                if (!capturing && tape_out) capturing = 1'b1;
                if (capturing && busy) samples.push_back(tape_out);
            end
        end
    end

    logic [7:0] exp_q[$];

    // compare level runs; runs ending a byte before a data byte may be
    // stretched by a stall when allow_stall is set
    task automatic check_wave(input string tag, input bit allow_stall);
        logic       hc[$];
        bit         fl[$];
        logic       el[$];
        int         en[$];
        bit         ef[$];
        logic       ol[$];
        int         on[$];
        logic [7:0] b;
        int         n;
        int         bad;
        int         extra;
        n = exp_q.size();
        for (int j = 0; j < n; j++) begin
            b = exp_q[j];
            for (int k = 7; k >= 0; k--) begin
                hc.push_back(~b[k]);
                fl.push_back(1'b0);
                hc.push_back(b[k]);
                fl.push_back(k == 0 && j >= PL && j < n - 1);
            end
        end
        hc.push_back(1'b0);
        fl.push_back(1'b0);
        hc.push_back(1'b0);
        fl.push_back(1'b0);
        for (int i = 0; i < hc.size(); i++) begin
            if (i > 0 && hc[i] == el[el.size()-1]) begin
                en[en.size()-1] = en[en.size()-1] + H;
                ef[ef.size()-1] = ef[ef.size()-1] | fl[i];
            end else begin
                el.push_back(hc[i]);
                en.push_back(H);
                ef.push_back(fl[i]);
            end
        end
        for (int i = 0; i < samples.size(); i++) begin
            if (i > 0 && samples[i] == ol[ol.size()-1]) begin
                on[on.size()-1] = on[on.size()-1] + 1;
            end else begin
                ol.push_back(samples[i]);
                on.push_back(1);
            end
        end
        bad   = 0;
        extra = 0;
        if (ol.size() != el.size()) begin
            bad = 1000 + ol.size();
        end else begin
            for (int i = 0; i < el.size(); i++) begin
                if (ol[i] !== el[i]) bad++;
                else if (on[i] == en[i]) bad = bad;
                else if (allow_stall && ef[i] && on[i] > en[i])
                    extra += on[i] - en[i];
                else bad++;
            end
        end
        chk({tag, "_runs"}, bad, 0);
        if (allow_stall) chk({tag, "_stall"}, extra > 0, 1);
    endtask

    task automatic play(input int len, input int latency,
                        input bit poke);
        int n;
        lat      = latency;
        pend_cnt = 0;
        rd_count = 0;
        rd_addrs.delete();
        samples.delete();
        capturing = 1'b0;
        done_cnt  = 0;
        cap_on    = 1'b1;
        length    = 25'(len);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (10) @(negedge clk);
            length = 25'd5;
            start  = 1'b1;
            @(negedge clk);
            start  = 1'b0;
            length = 25'(len);
        end
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("end_wait", n < 5000, 1);
        repeat (2) @(negedge clk);
        cap_on = 1'b0;
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        length = '0;
        repeat (3) @(negedge clk);
        chk("rst_tape", tape_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_under", underrun, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // nominal stream, short latency
        play(2, 3, 1'b0);
        exp_q = '{8'h00, 8'h00, 8'hE6, 8'hA5, 8'h3C};
        check_wave("nom", 1'b0);
        chk("nom_done", done_cnt, 1);
        chk("nom_under", underrun, 0);
        chk("nom_rds", rd_count, 2);
        chk("nom_a0", (rd_addrs.size() > 0) ? rd_addrs[0] : 25'h1ffffff, 0);
        chk("nom_a1", (rd_addrs.size() > 1) ? rd_addrs[1] : 25'h1ffffff, 1);

        // slow memory: stalls at data byte boundaries
        play(2, 40, 1'b0);
        check_wave("slow", 1'b1);
        chk("slow_done", done_cnt, 1);
        chk("slow_under", underrun, 1);
        chk("slow_rds", rd_count, 2);

        // empty image
        play(0, 3, 1'b0);
        exp_q = '{8'h00, 8'h00, 8'hE6};
        check_wave("empty", 1'b0);
        chk("empty_done", done_cnt, 1);
        chk("empty_rds", rd_count, 0);
        chk("empty_under", underrun, 0);

        // start while busy is ignored
        play(2, 3, 1'b1);
        exp_q = '{8'h00, 8'h00, 8'hE6, 8'hA5, 8'h3C};
        check_wave("poke", 1'b0);
        chk("poke_done", done_cnt, 1);
        chk("poke_rds", rd_count, 2);

        // stop during data byte 1 (request for address 2 marks it)
        lat      = 3;
        pend_cnt = 0;
        done_cnt = 0;
        length   = 25'd4;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(mem_rd && mem_addr == 25'd2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("stop_wait", n < 2000, 1);
        chk("stop_pre_tape", tape_out, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_tape", tape_out, 0);
        chk("stop_busy", busy, 0);
        repeat (20) @(negedge clk);
        chk("stop_done", done_cnt, 0);

        // restart from address 0, then reset mid-sync
        pend_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!mem_rd && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("re_wait", n < 1000, 1);
        chk("re_addr", mem_addr, 0);
        chk("re_tape", tape_out, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_tape", tape_out, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rd", mem_rd, 0);
        chk("mid_addr", mem_addr, 0);
        chk("mid_done", done, 0);
        chk("mid_under", underrun, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_tape", tape_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rk_tape_player.md
RK_TAPE_PLAYER -- requirements
Module: rk_tape_player

Interface
REQ-001 Parameter HALF_DIV, default 1536: clk cycles per tape half-cell.
REQ-002 Parameter PILOT_LEN, default 256: number of 8'h00 pilot bytes before the sync byte.
REQ-003 Parameter SYNC_BYTE, default 8'hE6: sync marker emitted after the pilot.
REQ-004 Clocking is fixed: one clock, clk; reset is asynchronous and active-high, reset.
REQ-005 clk  in  1  system clock (clk_sys domain).
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins playback of the loaded image.
REQ-008 stop  in  1  one-cycle pulse; aborts playback.
REQ-009 length  in  25  image byte count; sampled on accepted start.
REQ-010 mem_rd  out  1  one-cycle byte-fetch request.
REQ-011 mem_addr  out  25  byte address for mem_rd, counting 0..length-1.
REQ-012 mem_valid  in  1  one-cycle strobe: mem_data is valid for the last request.
REQ-013 mem_data  in  8  fetched byte.
REQ-014 tape_out  out  1  cassette level, driving ppa1 port C bit 4 (tapein).
REQ-015 busy  out  1  high from accepted start until playback ends.
REQ-016 done  out  1  one-cycle pulse on normal completion.
REQ-017 underrun  out  1  sticky; set when a byte boundary arrives before its data; cleared on accepted start.

Function
REQ-018 FSM states: IDLE, PILOT, SYNC, DATA, TRAIL. Transitions: IDLE->PILOT on start; PILOT->SYNC after PILOT_LEN bytes; SYNC->DATA after one byte; DATA->TRAIL after length bytes; TRAIL->IDLE after 2 half-cells at level 0.
REQ-019 start is accepted only in IDLE and ignored otherwise; stop in any non-IDLE state returns to IDLE on the next clk with tape_out=0 and busy=0, and does not pulse done.
REQ-020 length=0 skips DATA: SYNC goes directly to TRAIL.
REQ-021 Each bit occupies two half-cells of HALF_DIV clk each; first half = ~bit, second half = bit; bits go out MSB first.
REQ-022 The half-cell counter counts HALF_DIV-1 down to 0; tape_out updates on the clk after it reaches 0; output is registered with no combinational path from inputs.
REQ-023 Byte prefetch: in DATA, and in SYNC when length>0, assert mem_rd once at the start of bit 0 (LSB) of the current byte for the next address; latch mem_data on mem_valid into a one-byte holding register.
REQ-024 If the holding register is empty at a byte boundary: hold tape_out, freeze the counter, set underrun, and resume on mem_valid with a full HALF_DIV half-cell.
REQ-025 mem_valid with no outstanding request is ignored; a second mem_rd is never issued while a request is outstanding.
REQ-026 mem_addr wraps never; the byte counter is 25 bits, compared against length.
REQ-027 done pulses on the TRAIL->IDLE transition; busy falls in the same cycle.

Reset
REQ-028 On reset: state=IDLE, tape_out=0, busy=0, done=0, mem_rd=0, mem_addr=0, underrun=0, counters and holding register cleared; reset asserted mid-playback behaves identically.

Structure
REQ-029 A shared package rk_tape_pkg holds the state enum and the SYNC_BYTE/PILOT_LEN defaults.
REQ-030 One sub-module, rk_bit_serializer: 8-bit shift register plus half-cell counter, exposing load/ready/level.

Verification
REQ-031 HALF_DIV=4, PILOT_LEN=2, length=2, memory returns A5,3C after 3 clk -> waveform is 00,00,E6,A5,3C Manchester-encoded; done once; underrun=0.
REQ-032 Same as REQ-031 with memory latency 40 clk -> stall at the first data byte; underrun=1; bit stream is otherwise identical; tape_out is held steady during the stall.
REQ-033 length=0 -> pilot, then E6, then trail; mem_rd is never asserted.
REQ-034 stop during DATA byte 1 -> next clk tape_out=0, busy=0, no done; a new start restarts at mem_addr 0.
REQ-035 reset asserted mid-SYNC (asynchronously, between edges) -> all outputs go to reset values immediately.
REQ-036 start while busy -> ignored; the stream and byte count are unchanged.
